// File: rtl/adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
//   Registered WIDTH-bit adder/subtractor built from one ripple-carry chain.
//   SUB=1 inverts B and injects a carry-in of 1, so the same chain computes
//   A + ~B + 1 = A - B. The overflow flag V is interpreted per U:
//   unsigned carry/borrow, or two's-complement signed overflow.
//
// Ports
//   clk  in   single clock, all state updates on its rising edge
//   rst  in   synchronous active-high reset (clears S and V)
//   A    in   [WIDTH-1:0] first operand / minuend
//   B    in   [WIDTH-1:0] second operand / subtrahend
//   SUB  in   0: A+B, 1: A-B
//   U    in   1: unsigned operands, 0: two's-complement signed operands
//   S    out  [WIDTH-1:0] registered result, wraps modulo 2^WIDTH
//   V    out  registered overflow / out-of-range flag
// ---------------------------------------------------------------------------
module adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             U,
  output logic [WIDTH-1:0] S,
  output logic             V
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_q, s_d;
  logic             v_q, v_d;

  logic             flag_unsigned;
  logic             flag_signed;

  assign b_eff    = B ^ {WIDTH{SUB}};
  assign carry[0] = SUB;

  // One full adder per bit; carry ripples from LSB to MSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign r[gi]       = A[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & b_eff[gi]) | (carry[gi] & (A[gi] ^ b_eff[gi]));
    end
  endgenerate

  // Unsigned: carry-out on add, inverted carry-out (borrow) on subtract.
  assign flag_unsigned = carry[WIDTH] ^ SUB;

  // Signed: the effective operands share a sign but the result's sign
  // differs. Using b_eff covers both add (A,B same sign) and subtract
  // (A,B opposite signs) with a single expression.
  assign flag_signed = (A[WIDTH-1] == b_eff[WIDTH-1]) && (r[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    s_d = r;
    v_d = U ? flag_unsigned : flag_signed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  assign S = s_q;
  assign V = v_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_adder_subtractor
//   Directed-vector bench for adder_subtractor (WIDTH=4): reset, the listed
//   add/subtract cases in both interpretations, a mid-stream reset and a full
//   sweep of all operand pairs in every mode against an integer model.
// ---------------------------------------------------------------------------
module tb_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_in, b_in;
  logic       sub_in, u_in;
  logic [3:0] s_out;
  logic       v_out;

  int n_vec   = 0;
  int n_fails = 0;

  adder_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .B   (b_in),
    .SUB (sub_in),
    .U   (u_in),
    .S   (s_out),
    .V   (v_out)
  );

  always #5 clk = ~clk;

  // Integer reference: true arithmetic result checked against the range of
  // the chosen interpretation.
  function automatic void ref_model(input int a, input int b, input bit sub, input bit u,
                                    output logic [3:0] s, output logic v);
    int t, sa, sb, st;
    t  = sub ? (a - b) : (a + b);
    s  = t[3:0];
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    st = sub ? (sa - sb) : (sa + sb);
    if (u) v = sub ? (a < b) : (t > 15);
    else   v = (st > 7) || (st < -8);
  endfunction

  // Apply one set of inputs, clock once, then check the registered outputs.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic sub,
                      input logic u, input logic r, input logic [3:0] es,
                      input logic ev, input string tag);
    a_in = a; b_in = b; sub_in = sub; u_in = u; rst = r;
    @(posedge clk);
    #1;
    n_vec++;
    assert (s_out === es && v_out === ev)
    else begin
      n_fails++;
      $error("FAIL %s: A=%0d B=%0d SUB=%0b U=%0b rst=%0b got S=%0d V=%0b expected S=%0d V=%0b",
             tag, a, b, sub, u, r, s_out, v_out, es, ev);
    end
    $display("%s: A=%0d B=%0d SUB=%0b U=%0b rst=%0b -> S=%0d V=%0b", tag, a, b, sub, u, r, s_out, v_out);
  endtask

  initial begin
    logic [3:0] es;
    logic       ev;

    // Reset with inputs that would otherwise produce a nonzero result.
    step(4'd15, 4'd15, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "reset");
    step(4'd9,  4'd8,  1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "reset_hold");

    // Unsigned add
    step(4'd9,  4'd8,  1'b0, 1'b1, 1'b0, 4'd1,  1'b1, "uadd_9_8");
    step(4'd7,  4'd8,  1'b0, 1'b1, 1'b0, 4'd15, 1'b0, "uadd_7_8");
    step(4'd15, 4'd1,  1'b0, 1'b1, 1'b0, 4'd0,  1'b1, "uadd_15_1");
    // Unsigned subtract
    step(4'd3,  4'd5,  1'b1, 1'b1, 1'b0, 4'd14, 1'b1, "usub_3_5");
    step(4'd5,  4'd3,  1'b1, 1'b1, 1'b0, 4'd2,  1'b0, "usub_5_3");
    step(4'd7,  4'd7,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, "usub_7_7");
    // Signed add
    step(4'd7,  4'd1,  1'b0, 1'b0, 1'b0, 4'd8,  1'b1, "sadd_7_1");
    step(4'd8,  4'd15, 1'b0, 1'b0, 1'b0, 4'd7,  1'b1, "sadd_8_15");
    step(4'd15, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, "sadd_15_1");
    // Signed subtract
    step(4'd8,  4'd1,  1'b1, 1'b0, 1'b0, 4'd7,  1'b1, "ssub_8_1");
    step(4'd0,  4'd8,  1'b1, 1'b0, 1'b0, 4'd8,  1'b1, "ssub_0_8");
    step(4'd7,  4'd15, 1'b1, 1'b0, 1'b0, 4'd8,  1'b1, "ssub_7_15");
    step(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, "ssub_15_15");
    step(4'd8,  4'd8,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, "ssub_8_8");
    // Zero operands in every mode
    step(4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  1'b0, "zero_uadd");
    step(4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, "zero_usub");
    step(4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, "zero_sadd");
    step(4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, "zero_ssub");

    // Mid-stream reset: back-to-back ops, one reset cycle, then resume.
    step(4'd9,  4'd8,  1'b0, 1'b1, 1'b0, 4'd1,  1'b1, "mid_pre");
    step(4'd7,  4'd1,  1'b0, 1'b0, 1'b1, 4'd0,  1'b0, "mid_rst");
    step(4'd3,  4'd5,  1'b1, 1'b1, 1'b0, 4'd14, 1'b1, "mid_post");
    step(4'd7,  4'd15, 1'b1, 1'b0, 1'b0, 4'd8,  1'b1, "mid_post2");

    // Full sweep, one operation per cycle, mode changing every 256 cycles.
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          ref_model(a, b, m[0], m[1], es, ev);
          step(4'(a), 4'(b), m[0], m[1], 1'b0, es, ev, "sweep");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fails);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits; all requirements below use WIDTH=4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port A, input, WIDTH bits, the first operand (minuend for subtraction).
REQ-005 The block SHALL have port B, input, WIDTH bits, the second operand (subtrahend for subtraction).
REQ-006 The block SHALL have port SUB, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-007 The block SHALL have port U, input, 1 bit: 1 treats operands as unsigned, 0 treats them as two's-complement signed.
REQ-008 The block SHALL have port S, output, WIDTH bits, the registered result.
REQ-009 The block SHALL have port V, output, 1 bit, the registered overflow/out-of-range flag.

Function
REQ-010 The datapath SHALL be a single ripple-carry adder with B XOR-ed with SUB and carry-in equal to SUB, giving A + (B ^ {WIDTH{SUB}}) + SUB.
REQ-011 The raw result R SHALL be the low WIDTH bits of that sum, i.e. (A+B) mod 2^WIDTH or (A-B) mod 2^WIDTH, and SHALL be identical for U=0 and U=1.
REQ-012 With U=1, SUB=0, V SHALL equal the carry-out (true sum > 2^WIDTH-1).
REQ-013 With U=1, SUB=1, V SHALL equal the borrow, i.e. NOT carry-out (asserted exactly when A < B).
REQ-014 With U=0, SUB=0, V SHALL be asserted exactly when A[MSB]==B[MSB] and R[MSB]!=A[MSB].
REQ-015 With U=0, SUB=1, V SHALL be asserted exactly when A[MSB]!=B[MSB] and R[MSB]!=A[MSB].
REQ-016 On every rising clk edge with rst=0, S SHALL load R and V SHALL load the flag computed from the A, B, SUB and U values present at that edge.
REQ-017 Latency SHALL be exactly one clock cycle, and a new operation SHALL be accepted every cycle with no handshake.
REQ-018 Changing SUB or U between cycles SHALL take effect on the very next edge, with no dependence on previous operations.
REQ-019 S SHALL wrap modulo 2^WIDTH in all modes, with no saturation.
REQ-020 Edge cases SHALL hold: A=B=0 in any mode gives S=0, V=0; unsigned 15+1 gives S=0, V=1; signed 8-8, i.e. (-8)-(-8), gives S=0, V=0.

Reset
REQ-021 When rst=1 at a rising clk edge, S SHALL become 0 and V SHALL become 0, regardless of the other inputs.
REQ-022 Reset SHALL take priority over any computation at the same edge, and the first edge with rst=0 SHALL load a normal result.
REQ-023 Outputs SHALL be undefined only before the first clock edge; no asynchronous path from rst to S or V is permitted.

Verification
REQ-024 Unsigned add (U=1, SUB=0): A=9, B=8 gives S=1, V=1; A=7, B=8 gives S=15, V=0, each one cycle after the inputs are applied.
REQ-025 Unsigned subtract (U=1, SUB=1): A=3, B=5 gives S=14, V=1; A=5, B=3 gives S=2, V=0; A=B=7 gives S=0, V=0.
REQ-026 Signed add (U=0, SUB=0): A=7, B=1 gives S=8, V=1; A=8, B=15 gives S=7, V=1; A=15, B=1 gives S=0, V=0.
REQ-027 Signed subtract (U=0, SUB=1): A=8, B=1 gives S=7, V=1; A=0, B=8 gives S=8, V=1; A=7, B=15 gives S=8, V=1; A=15, B=15 gives S=0, V=0.
REQ-028 Reset mid-stream: during back-to-back operations, assert rst for one cycle; S=0 and V=0 the next cycle, and the correct result resumes one cycle after rst is released.
REQ-029 Exhaustive sweep: all 16x16 A/B pairs in each of the four SUB/U modes (1024 cases), one per cycle, SHALL match a reference model of REQ-011 to REQ-015 with one-cycle alignment.
